// File: rtl/keypad_scan_if.sv
// Signal bundle between the 4x3 keypad scanner and its keypad and consumers.
// The master side is the scanner; the slave side is the keypad and watch.
interface keypad_scan_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] num_input;
  logic       set_time;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    input  key_row,
    output key_col, num_input, set_time, key_code, key_valid
  );

  modport slave (
    output key_row,
    input  key_col, num_input, set_time, key_code, key_valid
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner with frame-based debounce; produces the
// watch digit and '#' levels plus a key_code and a one-cycle key_valid strobe.
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 2,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [3:0]  NO_KEY = 4'd15;

  typedef enum logic [1:0] {COL0, COL1, COL2} col_t;

  col_t             col_idx, col_next;
  logic [DIV_W-1:0] div_cnt;
  logic             sample;
  logic [11:0]      bitmap;
  logic             frame_done;
  logic [3:0]       raw;
  logic [3:0]       hits;
  logic [3:0]       candidate, next_cand;
  logic [CNT_W-1:0] stable_cnt, next_cnt;
  logic             accept;
  logic [3:0]       accepted;
  logic [9:0]       num_next;

  // Bitmap layout: bit index = col*4 + row.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 4'd1;
      4'd1:    key_map = 4'd4;
      4'd2:    key_map = 4'd7;
      4'd3:    key_map = 4'd10;
      4'd4:    key_map = 4'd2;
      4'd5:    key_map = 4'd5;
      4'd6:    key_map = 4'd8;
      4'd7:    key_map = 4'd0;
      4'd8:    key_map = 4'd3;
      4'd9:    key_map = 4'd6;
      4'd10:   key_map = 4'd9;
      4'd11:   key_map = 4'd11;
      default: key_map = NO_KEY;
    endcase
  endfunction

  // Column scan state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx    <= COL0;
      kp.key_col <= 3'b001;
    end else begin
      col_idx    <= col_next;
      kp.key_col <= 3'b001 << col_next;
    end
  end

  always_comb begin
    sample   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    col_next = col_idx;
    if (sample) begin
      case (col_idx)
        COL0:    col_next = COL1;
        COL1:    col_next = COL2;
        default: col_next = COL0;
      endcase
    end
  end

  // Rows are sampled only in the last cycle of each column slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bitmap     <= '0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= sample ? '0 : div_cnt + 1'b1;
      frame_done <= sample && (col_idx == COL2);
      if (sample) begin
        case (col_idx)
          COL0:    bitmap[3:0]  <= kp.key_row;
          COL1:    bitmap[7:4]  <= kp.key_row;
          default: bitmap[11:8] <= kp.key_row;
        endcase
      end
    end
  end

  // Exactly one closed switch decodes to a key; none or several is NO_KEY.
  always_comb begin
    raw  = NO_KEY;
    hits = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (bitmap[i]) begin
        hits = hits + 4'd1;
        raw  = key_map(4'(i));
      end
    end
    if (hits != 4'd1) raw = NO_KEY;
  end

  always_comb begin
    next_cand = candidate;
    next_cnt  = stable_cnt;
    accept    = 1'b0;
    if (frame_done) begin
      if (raw != candidate) begin
        next_cand = raw;
        next_cnt  = CNT_W'(1);
      end else if (stable_cnt != CNT_W'(DEBOUNCE_FRAMES)) begin
        next_cnt = stable_cnt + 1'b1;
      end
      accept = (next_cnt == CNT_W'(DEBOUNCE_FRAMES)) && (next_cand != accepted);
    end
  end

  always_comb begin
    num_next = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (next_cand == 4'(k)) num_next[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate    <= NO_KEY;
      stable_cnt   <= '0;
      accepted     <= NO_KEY;
      kp.num_input <= '0;
      kp.set_time  <= 1'b0;
      kp.key_valid <= 1'b0;
    end else begin
      candidate    <= next_cand;
      stable_cnt   <= next_cnt;
      kp.key_valid <= accept && (next_cand != NO_KEY);
      if (accept) begin
        accepted     <= next_cand;
        kp.num_input <= num_next;
        kp.set_time  <= (next_cand == 4'd11);
      end
    end
  end

  assign kp.key_code = accepted;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: models the matrix as
// key_row[r] = |(pressed[r] & key_col) and checks hand-computed cycle timing.
module tb_keypad_scan;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0][2:0] pressed;
  int              checks = 0;
  int              errors = 0;
  int              pulses = 0;
  int              base   = 0;
  int              cyc    = 0;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(2), .DEBOUNCE_FRAMES(5)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    kif.key_row = '0;
    for (int r = 0; r < 4; r++) kif.key_row[r] = |(pressed[r] & kif.key_col);
  end

  always @(posedge clk) if (kif.key_valid === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [2:0] col_at(input int c);
    case ((c % 6) / 2)
      0:       col_at = 3'b001;
      1:       col_at = 3'b010;
      default: col_at = 3'b100;
    endcase
  endfunction

  initial begin
    pressed = '0;
    repeat (3) @(negedge clk);
    pressed[1][1] = 1'b1;   // '5' held from the first frame
    rst = 1'b0;
    cyc = 0;

    check("rst_col",   kif.key_col,   3'b001);
    check("rst_code",  kif.key_code,  4'd15);
    check("rst_num",   kif.num_input, 10'd0);
    check("rst_set",   kif.set_time,  1'b0);
    check("rst_valid", kif.key_valid, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step_to(i);
      check("col_seq", kif.key_col, col_at(i));
    end
    base = pulses;

    // '5': frames done at 6..30, accept visible in cycle 31
    step_to(30);
    check("k5_early_code",  kif.key_code,  4'd15);
    check("k5_early_valid", kif.key_valid, 1'b0);
    step_to(31);
    check("k5_valid", kif.key_valid, 1'b1);
    check("k5_code",  kif.key_code,  4'd5);
    check("k5_num",   kif.num_input, 10'b00_0010_0000);
    check("k5_set",   kif.set_time,  1'b0);
    step_to(32);
    check("k5_valid_drop", kif.key_valid, 1'b0);
    check("k5_pulses", pulses - base, 1);

    // release '5': first empty frame done at 36, release visible at 61
    pressed = '0;
    base = pulses;
    step_to(60);
    check("rel_hold_code", kif.key_code,  4'd5);
    check("rel_hold_num",  kif.num_input, 10'b00_0010_0000);
    step_to(61);
    check("rel_code",    kif.key_code,  4'd15);
    check("rel_num",     kif.num_input, 10'd0);
    check("rel_valid",   kif.key_valid, 1'b0);
    check("rel_nopulse", pulses - base, 0);

    // '#': frames done at 66..90, accept visible in cycle 91
    pressed[3][2] = 1'b1;
    base = pulses;
    step_to(90);
    check("hash_early_set",  kif.set_time, 1'b0);
    check("hash_early_code", kif.key_code, 4'd15);
    step_to(91);
    check("hash_valid", kif.key_valid, 1'b1);
    check("hash_set",   kif.set_time,  1'b1);
    check("hash_code",  kif.key_code,  4'd11);
    check("hash_num",   kif.num_input, 10'd0);
    step_to(92);
    check("hash_valid_drop", kif.key_valid, 1'b0);
    check("hash_pulses", pulses - base, 1);

    // '3' bouncing for 8 frames (on/off), held from cycle 140
    base = pulses;
    for (int k = 0; k < 8; k++) begin
      step_to(92 + 6 * k);
      pressed = '0;
      if (k % 2 == 0) pressed[0][2] = 1'b1;
    end
    step_to(140);
    pressed = '0;
    pressed[0][2] = 1'b1;
    step_to(168);
    check("bounce_code",    kif.key_code, 4'd11);
    check("bounce_set",     kif.set_time, 1'b1);
    check("bounce_nopulse", pulses - base, 0);

    // '1'+'2' together from a frame boundary: decodes to no key
    pressed = '0;
    pressed[0][0] = 1'b1;
    pressed[0][1] = 1'b1;
    step_to(169);
    check("k3_valid", kif.key_valid, 1'b1);
    check("k3_code",  kif.key_code,  4'd3);
    check("k3_num",   kif.num_input, 10'b00_0000_1000);
    check("k3_set",   kif.set_time,  1'b0);
    step_to(170);
    check("k3_pulses", pulses - base, 1);
    base = pulses;
    step_to(198);
    check("multi_hold_code", kif.key_code, 4'd3);
    step_to(199);
    check("multi_code",  kif.key_code,  4'd15);
    check("multi_num",   kif.num_input, 10'd0);
    check("multi_valid", kif.key_valid, 1'b0);
    step_to(228);
    check("multi_stay_code", kif.key_code, 4'd15);
    check("multi_nopulse",   pulses - base, 0);

    // '7' mid-debounce, then asynchronous reset while column 1 is driven
    pressed = '0;
    pressed[2][0] = 1'b1;
    step_to(242);
    check("pre_rst_col", kif.key_col, 3'b010);
    rst = 1'b1;
    #1;
    check("arst_col",   kif.key_col,   3'b001);
    check("arst_code",  kif.key_code,  4'd15);
    check("arst_num",   kif.num_input, 10'd0);
    check("arst_set",   kif.set_time,  1'b0);
    check("arst_valid", kif.key_valid, 1'b0);
    repeat (2) @(negedge clk);
    check("arst_hold_col", kif.key_col, 3'b001);
    rst = 1'b0;
    cyc = 0;
    base = pulses;

    // '7' still held: re-accepted from scratch after full latency
    step_to(30);
    check("k7_early_code",  kif.key_code,  4'd15);
    check("k7_early_valid", kif.key_valid, 1'b0);
    step_to(31);
    check("k7_valid", kif.key_valid, 1'b1);
    check("k7_code",  kif.key_code,  4'd7);
    check("k7_num",   kif.num_input, 10'b00_1000_0000);
    step_to(40);
    check("k7_pulses", pulses - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
